sdram_arbiter: RTL and testbench

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arb_pkg.sv | 20 ++
 rtl/sdram_arb_tag_fifo.sv | 48 ++++
 rtl/sdram_arbiter.sv | 154 +++++++++++++++
 tb/tb_sdram_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the SDRAM read/download arbiter.
package sdram_arb_pkg;

  localparam int unsigned DEF_NUM_REQ         = 4;
  localparam int unsigned DEF_ADDR_WIDTH      = 23;
  localparam int unsigned DEF_DATA_WIDTH      = 32;
  localparam int unsigned DEF_MAX_OUTSTANDING = 4;
  localparam int unsigned TAG_W               = $clog2(DEF_NUM_REQ);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_e;

  // Tag width for a given requester count; never below one bit.
  function automatic int unsigned tag_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// Owner-tag FIFO tracking in-flight SDRAM reads in issue order.
module sdram_arb_tag_fifo
  import sdram_arb_pkg::*;
#(
  parameter int unsigned WIDTH = TAG_W,
  parameter int unsigned DEPTH = DEF_MAX_OUTSTANDING
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= din;
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Arbitrates requester reads and ROM-download writes onto one SDRAM port.
// Define SDRAM_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ         = DEF_NUM_REQ,
  parameter int unsigned ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          dl_active,
  input  logic                          dl_req,
  input  logic [ADDR_WIDTH-1:0]         dl_addr,
  input  logic [DATA_WIDTH-1:0]         dl_data,
  input  logic [NUM_REQ-1:0]            rd_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_REQ-1:0]            rd_ack,
  output logic [NUM_REQ-1:0]            rd_valid,
  output logic [DATA_WIDTH-1:0]         rd_q,
  output logic                          sdram_req,
  output logic [ADDR_WIDTH-1:0]         sdram_addr,
  output logic [DATA_WIDTH-1:0]         sdram_data,
  output logic                          sdram_we,
  input  logic                          sdram_ack,
  input  logic                          sdram_valid,
  input  logic [DATA_WIDTH-1:0]         sdram_q,
  output logic                          err_orphan
);

  localparam int unsigned TW = tag_width(NUM_REQ);

  arb_state_e              state;
  logic [TW-1:0]           owner;
  logic [NUM_REQ-1:0]      req_eff;
  logic [ADDR_WIDTH-1:0]   req_addr [NUM_REQ];
  logic                    grant_valid;
  logic [TW-1:0]           grant_idx;
  logic                    can_read;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [TW-1:0]           tag_head;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_addr[g] = rd_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Reads are shut out entirely while a ROM download owns the port.
  assign req_eff = dl_active ? '0 : rd_req;

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  logic [TW-1:0] rr_ptr;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      logic [TW-1:0] idx;
      idx = TW'((32'(rr_ptr) + k) % NUM_REQ);
      if (!grant_valid && req_eff[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end
`else
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!grant_valid && req_eff[TW'(k)]) begin
        grant_valid = 1'b1;
        grant_idx   = TW'(k);
      end
    end
  end
`endif

  // A pop in the grant cycle frees the slot the new read will need.
  assign can_read  = !fifo_full || fifo_pop;
  assign fifo_push = (state == ISSUE) && sdram_ack && !sdram_we;
  assign fifo_pop  = sdram_valid && !fifo_empty;

  assign rd_ack   = fifo_push ? (NUM_REQ'(1) << owner) : '0;
  assign rd_valid = fifo_pop ? (NUM_REQ'(1) << tag_head) : '0;
  assign rd_q     = sdram_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      sdram_data <= '0;
      sdram_we   <= 1'b0;
      owner      <= '0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      rr_ptr     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (dl_active && dl_req) begin
            state      <= ISSUE;
            sdram_req  <= 1'b1;
            sdram_we   <= 1'b1;
            sdram_addr <= dl_addr;
            sdram_data <= dl_data;
          end else if (grant_valid && can_read) begin
            state      <= ISSUE;
            sdram_req  <= 1'b1;
            sdram_we   <= 1'b0;
            sdram_addr <= req_addr[grant_idx];
            owner      <= grant_idx;
          end
        end
        ISSUE: begin
          // Latched request holds regardless of rd_req or dl_active changes.
          if (sdram_ack) begin
            state     <= IDLE;
            sdram_req <= 1'b0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
            if (!sdram_we)
              rr_ptr <= (32'(owner) == NUM_REQ - 1) ? '0 : owner + TW'(1);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           err_orphan <= 1'b0;
    else if (sdram_valid && fifo_empty)  err_orphan <= 1'b1;
  end

  sdram_arb_tag_fifo #(
    .WIDTH (TW),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (owner),
    .dout  (tag_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed plus randomized bench for sdram_arbiter against a queue-based model.
module tb_sdram_arbiter;

  localparam int NR   = 4;
  localparam int AW   = 23;
  localparam int DW   = 32;
  localparam int MAXO = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             dl_active = 1'b0;
  logic             dl_req = 1'b0;
  logic [AW-1:0]    dl_addr = '0;
  logic [DW-1:0]    dl_data = '0;
  logic [NR-1:0]    rd_req = '0;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR-1:0]    rd_ack;
  logic [NR-1:0]    rd_valid;
  logic [DW-1:0]    rd_q;
  logic             sdram_req;
  logic [AW-1:0]    sdram_addr;
  logic [DW-1:0]    sdram_data;
  logic             sdram_we;
  logic             sdram_ack = 1'b0;
  logic             sdram_valid = 1'b0;
  logic [DW-1:0]    sdram_q = '0;
  logic             err_orphan;

  int checks = 0;
  int errors = 0;

  // Reference model: one pending transaction plus a queue of owners awaiting data.
  bit            m_busy;
  bit            m_we;
  int            m_owner;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  bit            m_orphan;
  int            tagq[$];
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  int            m_rr;
`endif

  always #5 clk = ~clk;

  sdram_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .dl_active   (dl_active),
    .dl_req      (dl_req),
    .dl_addr     (dl_addr),
    .dl_data     (dl_data),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_ack      (rd_ack),
    .rd_valid    (rd_valid),
    .rd_q        (rd_q),
    .sdram_req   (sdram_req),
    .sdram_addr  (sdram_addr),
    .sdram_data  (sdram_data),
    .sdram_we    (sdram_we),
    .sdram_ack   (sdram_ack),
    .sdram_valid (sdram_valid),
    .sdram_q     (sdram_q),
    .err_orphan  (err_orphan)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_we = 0; m_owner = 0; m_addr = '0; m_data = '0; m_orphan = 0;
    tagq.delete();
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    m_rr = 0;
`endif
  endtask

  // Compare against the model, then advance the model across the next rising edge.
  task automatic step();
    logic [NR-1:0] exp_ack;
    logic [NR-1:0] exp_val;
    int sz_after;
    int start;
    int w;
    bit popping;
    #1;
    exp_ack = (m_busy && !m_we && sdram_ack) ? (NR'(1) << m_owner) : '0;
    exp_val = (sdram_valid && tagq.size() > 0) ? (NR'(1) << tagq[0]) : '0;
    chk("sdram_req", sdram_req, m_busy);
    if (m_busy) begin
      chk("sdram_we", sdram_we, m_we);
      chk("sdram_addr", sdram_addr, m_addr);
      if (m_we) chk("sdram_data", sdram_data, m_data);
    end
    chk("rd_ack", rd_ack, exp_ack);
    chk("rd_valid", rd_valid, exp_val);
    chk("rd_q", rd_q, sdram_q);
    chk("err_orphan", err_orphan, m_orphan);

    popping  = sdram_valid && tagq.size() > 0;
    if (sdram_valid && tagq.size() == 0) m_orphan = 1;
    sz_after = tagq.size() - int'(popping);
    if (popping) void'(tagq.pop_front());
    if (m_busy) begin
      if (sdram_ack) begin
        m_busy = 0;
        if (!m_we) begin
          tagq.push_back(m_owner);
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
          m_rr = (m_owner + 1) % NR;
`endif
        end
      end
    end else if (dl_active && dl_req) begin
      m_busy = 1; m_we = 1; m_addr = dl_addr; m_data = dl_data;
    end else if (!dl_active && rd_req != '0 && sz_after < MAXO) begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      start = m_rr;
`else
      start = 0;
`endif
      w = -1;
      for (int k = 0; k < NR; k++)
        if (w < 0 && rd_req[(start + k) % NR]) w = (start + k) % NR;
      m_busy = 1; m_we = 0; m_owner = w; m_addr = rd_addr[w*AW +: AW];
    end
    @(negedge clk);
  endtask

  task automatic set_addr(input int w, input logic [AW-1:0] a);
    rd_addr[w*AW +: AW] = a;
  endtask

  task automatic do_read(input int w);
    rd_req = NR'(1) << w;
    step();
    rd_req = '0;
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * MAXO && tagq.size() > 0; i++) begin
      sdram_valid = 1'b1;
      sdram_q = $urandom;
      step();
    end
    sdram_valid = 1'b0;
  endtask

  initial begin
    int exp_order[5];
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 2, 3, 0};
`else
    exp_order = '{0, 0, 0, 0, 0};
`endif
    model_reset();
    for (int i = 0; i < NR; i++) set_addr(i, AW'(24'h100000 + i * 24'h11));

    // Reset values
    @(negedge clk);
    chk("rst_req", sdram_req, 1'b0);
    chk("rst_we", sdram_we, 1'b0);
    chk("rst_addr", sdram_addr, '0);
    chk("rst_data", sdram_data, '0);
    chk("rst_ack", rd_ack, '0);
    chk("rst_valid", rd_valid, '0);
    chk("rst_orphan", err_orphan, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // All requesters held, every grant acked
    rd_req = '1;
    for (int i = 0; i < 5; i++) begin
      step();
      sdram_ack = 1'b1;
      sdram_valid = (tagq.size() > 0);
      #1;
      chk("grant_order", rd_ack, NR'(1) << exp_order[i]);
      step();
      sdram_ack = 1'b0;
      sdram_valid = 1'b0;
    end
    rd_req = '0;
    step();
    drain();

    // Single request latency and ack timing
    set_addr(0, 23'h123456);
    rd_req = 4'b0001;
    step();
    #1;
    chk("lat_req", sdram_req, 1'b1);
    chk("lat_addr", sdram_addr, 23'h123456);
    step();
    sdram_ack = 1'b1;
    rd_req = '0;
    #1;
    chk("lat_rd_ack", rd_ack, 4'b0001);
    step();
    sdram_ack = 1'b0;
    #1;
    chk("lat_req_drop", sdram_req, 1'b0);
    step();
    drain();

    // Outstanding limit: four in flight blocks the fifth until one returns
    do_read(2); do_read(0); do_read(3); do_read(1);
    rd_req = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("full_block", sdram_req, 1'b0);
      step();
    end
    sdram_valid = 1'b1;
    sdram_q = 32'hCAFE0001;
    #1;
    chk("full_first_valid", rd_valid, 4'b0100);
    step();
    sdram_valid = 1'b0;
    #1;
    chk("full_fifth_req", sdram_req, 1'b1);
    sdram_ack = 1'b1;
    rd_req = '0;
    step();
    sdram_ack = 1'b0;
    drain();

    // Download asserted while a read is latched; read still completes
    rd_req = 4'b0100;
    step();
    dl_active = 1'b1;
    rd_req = '0;
    step();
    sdram_ack = 1'b1;
    #1;
    chk("dl_mid_issue_ack", rd_ack, 4'b0100);
    step();
    sdram_ack = 1'b0;
    drain();

    // Download write with a masked read pending
    dl_req = 1'b1;
    dl_addr = 23'h000100;
    dl_data = 32'hDEADBEEF;
    rd_req = 4'b0010;
    step();
    dl_req = 1'b0;
    #1;
    chk("wr_req", sdram_req, 1'b1);
    chk("wr_we", sdram_we, 1'b1);
    chk("wr_addr", sdram_addr, 23'h000100);
    chk("wr_data", sdram_data, 32'hDEADBEEF);
    step();
    sdram_ack = 1'b1;
    #1;
    chk("wr_rd_ack", rd_ack, '0);
    step();
    sdram_ack = 1'b0;
    step();
    dl_active = 1'b0;
    rd_req = '0;

    // Orphan valid (also shows the write pushed no tag)
    sdram_valid = 1'b1;
    #1;
    chk("orphan_valid", rd_valid, '0);
    step();
    sdram_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("orphan_sticky", err_orphan, 1'b1);
      step();
    end

    // Reset during ISSUE, then stale read data arrives
    rd_req = 4'b0001;
    step();
    rd_req = '0;
    reset = 1'b1;
    #1;
    chk("rst_issue_req", sdram_req, 1'b0);
    chk("rst_issue_orphan", err_orphan, 1'b0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    sdram_valid = 1'b1;
    step();
    sdram_valid = 1'b0;
    #1;
    chk("post_rst_orphan", err_orphan, 1'b1);
    step();

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 39) == 0) dl_active = ~dl_active;
      dl_req  = dl_active && ($urandom_range(0, 3) == 0);
      dl_addr = AW'($urandom);
      dl_data = $urandom;
      rd_req  = NR'($urandom);
      for (int i = 0; i < NR; i++) set_addr(i, AW'($urandom));
      sdram_ack   = m_busy && ($urandom_range(0, 1) == 1);
      sdram_valid = (tagq.size() > 0) && ($urandom_range(0, 2) == 0);
      sdram_q     = $urandom;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
